mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares one single-ported memory between the instruction-fetch path (PC / Instruction_Memory side) and the data load/store path of the CPU. It sequences each access with a request/acknowledge handshake toward a variable-latency memory and returns read data to the winner. It also drives a fetch stall to the PC, and aborts any access the memory fails to acknowledge within a bounded time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum BUSY cycles before abort (must be >= 1)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- i_req_i  in  1  fetch request; held high with i_addr_i stable until i_ack_o
- i_addr_i  in  ADDR_W  fetch address
- i_ack_o  out  1  one-cycle fetch completion pulse
- i_rdata_o  out  DATA_W  fetch data; valid while i_ack_o=1
- d_req_i  in  1  data request; held high with d_addr_i, d_we_i and d_wdata_i stable until d_ack_o
- d_addr_i  in  ADDR_W  data address
- d_we_i  in  1  1 = write, 0 = read
- d_wdata_i  in  DATA_W  write data
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  DATA_W  load data; valid while d_ack_o=1 and the access was a read
- err_o  out  1  high together with the ack pulse when the access timed out
- if_stall_o  out  1  i_req_i & ~i_ack_o (combinational); holds the PC
- mem_req_o  out  1  memory request; held until mem_ack_i or timeout
- mem_addr_o  out  ADDR_W  registered address
- mem_we_o  out  1  registered write enable
- mem_wdata_o  out  DATA_W  registered write data
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o=1
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ack_i

## Operation
- FSM states:
  - IDLE: mem_req_o=0.
  - BUSY: mem_req_o=1.
- Registers:
  - owner (I/D): requester currently being served.
  - last_gnt (I/D): requester most recently granted.
  - timeout counter: width clog2(TIMEOUT+1).
- IDLE arbitration, evaluated on eligible requests. Eligible means req high and that requester's ack_o not high this cycle; this mask prevents re-granting a request being dropped.
  - Only one eligible: it wins.
  - Both eligible: the requester other than last_gnt wins (round-robin).
  - None eligible: stay in IDLE.
- On grant:
  - Latch addr/we/wdata into the mem_* registers. Fetch sets we=0 and wdata=0.
  - Set owner and last_gnt to the winner, clear the counter, go to BUSY.
- BUSY with mem_ack_i=1:
  - Next cycle: pulse the owner's ack_o, drive its rdata_o from registered mem_rdata_i, err_o=0, go to IDLE.
- BUSY with mem_ack_i=0: increment the counter.
  - If the counter reaches TIMEOUT-1 at this edge, abort instead: next cycle pulse the owner's ack_o with err_o=1 and rdata=0, go to IDLE.
- mem_ack_i while in IDLE (late ack after an abort) is ignored and has no effect.
- Write access: d_ack_o pulses; d_rdata_o is don't-care.
- Reset: state=IDLE, last_gnt=D (first tie goes to fetch). mem_req_o, mem_we_o, i_ack_o, d_ack_o and err_o are all 0. mem_addr_o, mem_wdata_o, i_rdata_o and d_rdata_o are 0.
- Reset asserted mid-BUSY drops mem_req_o the next cycle; the outstanding access is discarded and produces no ack.

## Timing
- Request high in cycle N while IDLE: mem_req_o is high in N+1.
- Zero-wait memory (mem_ack_i in N+1): ack_o in N+2. Minimum latency 2 cycles.
- k wait cycles: ack_o in N+2+k.
- Maximum throughput: one access per 2 cycles. A new grant can occur in the same cycle as the previous ack pulse, for the other requester only.
- Timeout: with no ack, mem_req_o stays high exactly TIMEOUT cycles (N+1 .. N+TIMEOUT). ack_o with err_o follows in N+TIMEOUT+1.
- At most one of i_ack_o/d_ack_o is high in any cycle.
- if_stall_o is high from the cycle i_req_i rises through the cycle before i_ack_o.

## Test plan
- Lone fetch, zero-wait memory: i_req_i=1, addr 0x0000_0004 at cycle 0; mem_ack_i=1, rdata 0x0050_0093 at cycle 1. Expect mem_req_o at cycle 1, i_ack_o=1 with i_rdata_o=0x0050_0093 at cycle 2, err_o=0.
- Simultaneous requests after reset: both requests high at cycle 0, ack 1 cycle after each mem_req_o. Expect fetch granted first, d_ack_o exactly one access later, then alternation I,D,I,D while both stay asserted.
- Data write, 3 wait states: d_we_i=1, addr 0x100, wdata 0xDEAD_BEEF. Expect mem_we_o=1 and mem_wdata_o=0xDEAD_BEEF, mem_req_o high 4 cycles, d_ack_o at request+5.
- Timeout, TIMEOUT=16, mem_ack_i tied 0: expect mem_req_o high exactly 16 cycles, then d_ack_o=1 with err_o=1 and rdata 0. A later mem_ack_i in IDLE produces no ack.
- Reset mid-BUSY, cycle 3 of a fetch: expect mem_req_o=0, no i_ack_o, and all outputs at reset values. After reset, a fetch completes normally.
- Stall check: fetch with 5 wait states. Expect if_stall_o=1 for cycles 0..6 and 0 at cycle 7, when i_ack_o=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and load/store paths.
// Round-robin on ties, one access in flight, and an abort when the memory never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_we_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              err_o,
    output logic              if_stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner_d;
    logic               r_last_d;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_i_ack;
    logic               r_d_ack;
    logic               r_err;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_we;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_i_rdata;
    logic [DATA_W-1:0]  r_d_rdata;

    logic               w_i_elig;
    logic               w_d_elig;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_done;
    logic               w_abort;
    logic [DATA_W-1:0]  w_ret_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A requester whose ack is pulsing this cycle is still holding req; mask it so it is not re-granted.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_i_elig    = i_req_i & ~r_i_ack;
        w_d_elig    = d_req_i & ~r_d_ack;
        case (r_state)
            ST_IDLE: begin
                if (w_i_elig && (!w_d_elig || r_last_d)) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ST_BUSY;
                end else if (w_d_elig) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_ret_data = w_abort ? '0 : mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner_d   <= 1'b0;
            r_last_d    <= 1'b1;
            r_cnt       <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_err   <= 1'b0;
            if (w_grant_i || w_grant_d) begin
                r_owner_d   <= w_grant_d;
                r_last_d    <= w_grant_d;
                r_cnt       <= '0;
                r_mem_addr  <= w_grant_d ? d_addr_i : i_addr_i;
                r_mem_we    <= w_grant_d & d_we_i;
                r_mem_wdata <= w_grant_d ? d_wdata_i : '0;
            end
            if (w_done || w_abort) begin
                r_err <= w_abort;
                if (r_owner_d) begin
                    r_d_ack   <= 1'b1;
                    r_d_rdata <= w_ret_data;
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= w_ret_data;
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_req_o   = (r_state == ST_BUSY);
    assign mem_addr_o  = r_mem_addr;
    assign mem_we_o    = r_mem_we;
    assign mem_wdata_o = r_mem_wdata;
    assign i_ack_o     = r_i_ack;
    assign d_ack_o     = r_d_ack;
    assign err_o       = r_err;
    assign i_rdata_o   = r_i_rdata;
    assign d_rdata_o   = r_d_rdata;
    assign if_stall_o  = i_req_i & ~r_i_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder with programmable wait states and a
// scoreboard of expected acknowledgements, checked against the DUT on every falling edge.
module tb_mem_port_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_ack_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i;
    logic [31:0] d_addr_i;
    logic        d_we_i;
    logic [31:0] d_wdata_i;
    logic        d_ack_o;
    logic [31:0] d_rdata_o;
    logic        err_o;
    logic        if_stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
        .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .err_o(err_o), .if_stall_o(if_stall_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_d;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Memory model: answers after wait_states busy cycles with addr ^ rd_key.
    bit          resp_en     = 1'b1;
    bit          force_ack   = 1'b0;
    int          wait_states = 0;
    logic [31:0] rd_key      = 32'h0;
    int          wc          = 0;

    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
    end

    always @(posedge clk_i) begin
        #1;
        if (!resp_en) begin
            mem_ack_i   = force_ack;
            mem_rdata_i = 32'hBAD0_BAD0;
            wc          = 0;
        end else if (mem_req_o === 1'b1) begin
            if (wc == wait_states) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_addr_o ^ rd_key;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'hBAD0_BAD0;
                wc++;
            end
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_BAD0;
            wc          = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push(input bit is_d, input bit err, input bit chk_rd, input logic [31:0] rdata);
        exp_t e;
        e.is_d   = is_d;
        e.err    = err;
        e.chk_rd = chk_rd;
        e.rdata  = rdata;
        sb_q.push_back(e);
    endtask

    // Scoreboard side: every ack pulse must match the oldest expected completion.
    always @(negedge clk_i) begin
        if (i_ack_o === 1'b1 || d_ack_o === 1'b1) begin
            exp_t e;
            chk("ack_onehot", {31'b0, i_ack_o & d_ack_o}, 32'h0);
            chk("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'h1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_port_d", {31'b0, d_ack_o}, {31'b0, e.is_d});
                chk("sb_err", {31'b0, err_o}, {31'b0, e.err});
                if (e.chk_rd) begin
                    chk("sb_rdata", e.is_d ? d_rdata_o : i_rdata_o, e.rdata);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_mem_req"},   {31'b0, mem_req_o}, 32'h0);
        chk({pfx, "_mem_we"},    {31'b0, mem_we_o},  32'h0);
        chk({pfx, "_i_ack"},     {31'b0, i_ack_o},   32'h0);
        chk({pfx, "_d_ack"},     {31'b0, d_ack_o},   32'h0);
        chk({pfx, "_err"},       {31'b0, err_o},     32'h0);
        chk({pfx, "_mem_addr"},  mem_addr_o,         32'h0);
        chk({pfx, "_mem_wdata"}, mem_wdata_o,        32'h0);
        chk({pfx, "_i_rdata"},   i_rdata_o,          32'h0);
        chk({pfx, "_d_rdata"},   d_rdata_o,          32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_i     = 1'b1;
        i_req_i   = 1'b0;
        i_addr_i  = 32'h0;
        d_req_i   = 1'b0;
        d_addr_i  = 32'h0;
        d_we_i    = 1'b0;
        d_wdata_i = 32'h0;
        step(2);
        chk_reset_outputs("rst");
        chk("rst_stall", {31'b0, if_stall_o}, 32'h0);
        rst_i = 1'b0;

        // Both requesters at once straight out of reset: fetch first, then strict alternation.
        wait_states = 0;
        rd_key      = 32'h1111_0000;
        i_req_i = 1'b1; i_addr_i = 32'h40;
        d_req_i = 1'b1; d_addr_i = 32'h200; d_we_i = 1'b0; d_wdata_i = 32'h1234;
        push(1'b0, 1'b0, 1'b1, 32'h40 ^ 32'h1111_0000);
        push(1'b1, 1'b0, 1'b1, 32'h200 ^ 32'h1111_0000);
        push(1'b0, 1'b0, 1'b1, 32'h40 ^ 32'h1111_0000);
        push(1'b1, 1'b0, 1'b1, 32'h200 ^ 32'h1111_0000);
        step(1);
        chk("rr_c1_mem_req", {31'b0, mem_req_o}, 32'h1);
        chk("rr_c1_addr", mem_addr_o, 32'h40);
        step(1);
        chk("rr_c2_i_ack", {31'b0, i_ack_o}, 32'h1);
        step(1);
        chk("rr_c3_addr", mem_addr_o, 32'h200);
        step(1);
        chk("rr_c4_d_ack", {31'b0, d_ack_o}, 32'h1);
        step(2);
        chk("rr_c6_i_ack", {31'b0, i_ack_o}, 32'h1);
        step(2);
        chk("rr_c8_d_ack", {31'b0, d_ack_o}, 32'h1);
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        step(1);
        chk("rr_c9_idle", {31'b0, mem_req_o}, 32'h0);

        // Lone fetch against a zero-wait memory.
        rd_key   = 32'h0050_0093 ^ 32'h4;
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_0004;
        push(1'b0, 1'b0, 1'b1, 32'h0050_0093);
        #1 chk("lone_stall_c0", {31'b0, if_stall_o}, 32'h1);
        step(1);
        chk("lone_c1_mem_req", {31'b0, mem_req_o}, 32'h1);
        chk("lone_c1_we", {31'b0, mem_we_o}, 32'h0);
        step(1);
        chk("lone_c2_i_ack", {31'b0, i_ack_o}, 32'h1);
        chk("lone_c2_rdata", i_rdata_o, 32'h0050_0093);
        chk("lone_c2_err", {31'b0, err_o}, 32'h0);
        i_req_i = 1'b0;
        step(1);
        chk("lone_c3_i_ack", {31'b0, i_ack_o}, 32'h0);

        // Data write with three wait states.
        wait_states = 3;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF;
        push(1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            step(1);
            chk($sformatf("wr_c%0d_mem_req", c), {31'b0, mem_req_o}, {31'b0, c <= 4});
            chk($sformatf("wr_c%0d_d_ack", c), {31'b0, d_ack_o}, {31'b0, c == 5});
            if (c == 1) begin
                chk("wr_we", {31'b0, mem_we_o}, 32'h1);
                chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
                chk("wr_addr", mem_addr_o, 32'h100);
            end
        end
        d_req_i = 1'b0;
        d_we_i  = 1'b0;

        // Silent memory: abort after exactly 16 request cycles, then ignore a late ack.
        step(1);
        resp_en  = 1'b0;
        d_req_i  = 1'b1;
        d_addr_i = 32'h300;
        push(1'b1, 1'b1, 1'b1, 32'h0);
        for (int c = 1; c <= 17; c++) begin
            step(1);
            chk($sformatf("to_c%0d_mem_req", c), {31'b0, mem_req_o}, {31'b0, c <= 16});
        end
        chk("to_d_ack", {31'b0, d_ack_o}, 32'h1);
        chk("to_err", {31'b0, err_o}, 32'h1);
        chk("to_rdata", d_rdata_o, 32'h0);
        d_req_i   = 1'b0;
        force_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("late_d_ack", {31'b0, d_ack_o}, 32'h0);
            chk("late_i_ack", {31'b0, i_ack_o}, 32'h0);
            chk("late_err", {31'b0, err_o}, 32'h0);
            chk("late_mem_req", {31'b0, mem_req_o}, 32'h0);
        end
        force_ack = 1'b0;
        resp_en   = 1'b1;
        step(1);

        // Reset during cycle 3 of a long fetch discards it without an ack.
        wait_states = 10;
        i_req_i  = 1'b1;
        i_addr_i = 32'h500;
        step(3);
        chk("rbusy_c3_mem_req", {31'b0, mem_req_o}, 32'h1);
        rst_i = 1'b1;
        step(1);
        chk_reset_outputs("rbusy");
        rst_i   = 1'b0;
        i_req_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("rbusy_no_ack", {31'b0, i_ack_o}, 32'h0);
        end

        wait_states = 1;
        rd_key   = 32'h0F0F_0000;
        i_req_i  = 1'b1;
        i_addr_i = 32'h80;
        push(1'b0, 1'b0, 1'b1, 32'h80 ^ 32'h0F0F_0000);
        lat = 0;
        while (lat < 20 && i_ack_o !== 1'b1) begin
            step(1);
            lat++;
        end
        chk("post_rst_ack", {31'b0, i_ack_o}, 32'h1);
        chk("post_rst_latency", lat, 32'd3);
        i_req_i = 1'b0;
        step(1);

        // Stall window for a fetch with five wait states.
        wait_states = 5;
        rd_key   = 32'h3C3C_0000;
        i_req_i  = 1'b1;
        i_addr_i = 32'h600;
        push(1'b0, 1'b0, 1'b1, 32'h600 ^ 32'h3C3C_0000);
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) step(1);
            #1;
            chk($sformatf("stall_c%0d", c), {31'b0, if_stall_o}, {31'b0, c != 7});
            if (c == 7) begin
                chk("stall_c7_i_ack", {31'b0, i_ack_o}, 32'h1);
                i_req_i = 1'b0;
            end
        end
        step(2);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
